wrb_port_arbiter: RTL and testbench

//  Shares a small number of physical_regfile write ports among many writeback requesters
//  (alu1/alu2/falu/lsu/md/fdivsqrt).
//  - Each cycle, round-robin selects up to NUM_WPORT valid requests.
//  - Returns per-requester ready; drives registered write-port outputs one cycle later.
//  - Sits between the execute-unit writeback buses and the regfile write ports inside the RCU.

---
 rtl/rcu_pkg.sv | 17 +
 rtl/rr_multi_picker.sv | 33 +++
 rtl/wrb_port_arbiter.sv | 113 +++++++++++
 tb/tb_wrb_port_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rcu_pkg.sv
// Shared RCU types and widths for the writeback path.
package rcu_pkg;
  localparam int XLEN           = 64;
  localparam int REG_SIZE_WIDTH = 7;

  typedef logic [REG_SIZE_WIDTH-1:0] preg_t;

  typedef struct packed {
    logic             valid;
    preg_t            address;
    logic [XLEN-1:0]  data;
  } wrb_req_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_multi_picker.sv
// Combinational circular-priority picker: grants the first NUM_WPORT set bits of req_i
// scanning upward from rr_ptr_i. The j-th grant lands in one-hot slice j of grant_o.
module rr_multi_picker #(
  parameter int NUM_REQ   = 5,
  parameter int NUM_WPORT = 2,
  parameter int PTR_W     = 3
) (
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [PTR_W-1:0]             rr_ptr_i,
  output logic [NUM_WPORT*NUM_REQ-1:0] grant_o,
  output logic                         any_o,
  output logic [PTR_W-1:0]             last_o
);

  always_comb begin
    int idx;
    int n;
    grant_o = '0;
    any_o   = 1'b0;
    last_o  = rr_ptr_i;
    n       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_i) + i) % NUM_REQ;
      if (req_i[idx] && (n < NUM_WPORT)) begin
        grant_o[n*NUM_REQ + idx] = 1'b1;
        last_o                   = PTR_W'(idx);
        any_o                    = 1'b1;
        n                        = n + 1;
      end
    end
  end

endmodule

// File: rtl/wrb_port_arbiter.sv
// Round-robin sharing of regfile write ports among writeback requesters.
// Ready is combinational in the grant cycle; write ports are registered one cycle later.
module wrb_port_arbiter #(
  parameter int NUM_REQ        = 5,
  parameter int NUM_WPORT      = 2,
  parameter int REG_SIZE_WIDTH = rcu_pkg::REG_SIZE_WIDTH,
  parameter int XLEN           = rcu_pkg::XLEN,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ*REG_SIZE_WIDTH-1:0]   req_address_i,
  input  logic [NUM_REQ*XLEN-1:0]             req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [NUM_WPORT-1:0]                wrb_valid_o,
  output logic [NUM_WPORT*REG_SIZE_WIDTH-1:0] wrb_address_o,
  output logic [NUM_WPORT*XLEN-1:0]           wrb_data_o,
  output logic [CNT_WIDTH-1:0]                conflict_cnt_o
);
  import rcu_pkg::*;

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [PTR_W-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]                  last_idx;
  logic                              any_grant;
  logic [NUM_WPORT*NUM_REQ-1:0]      grant;
  logic [NUM_WPORT-1:0]              wrb_valid_q, wrb_valid_d;
  logic [NUM_WPORT*REG_SIZE_WIDTH-1:0] wrb_address_q, wrb_address_d;
  logic [NUM_WPORT*XLEN-1:0]         wrb_data_q, wrb_data_d;
  logic [CNT_WIDTH-1:0]              conflict_cnt_q, conflict_cnt_d;

  rr_multi_picker #(
    .NUM_REQ   (NUM_REQ),
    .NUM_WPORT (NUM_WPORT),
    .PTR_W     (PTR_W)
  ) u_picker (
    .req_i    (req_valid_i),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant),
    .any_o    (any_grant),
    .last_o   (last_idx)
  );

  always_comb begin
    req_ready_o = '0;
    for (int p = 0; p < NUM_WPORT; p++) begin
      req_ready_o = req_ready_o | grant[p*NUM_REQ +: NUM_REQ];
    end
    if (rst) req_ready_o = '0;
  end

  // A grant to preg 0 still occupies its port slot but never writes; idle ports hold addr/data.
  always_comb begin
    wrb_valid_d   = '0;
    wrb_address_d = wrb_address_q;
    wrb_data_d    = wrb_data_q;
    for (int p = 0; p < NUM_WPORT; p++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (grant[p*NUM_REQ + k] &&
            (req_address_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] != '0)) begin
          wrb_valid_d[p] = 1'b1;
          wrb_address_d[p*REG_SIZE_WIDTH +: REG_SIZE_WIDTH] =
            req_address_i[k*REG_SIZE_WIDTH +: REG_SIZE_WIDTH];
          wrb_data_d[p*XLEN +: XLEN] = req_data_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    int pop;
    pop = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k]) pop = pop + 1;
    end
    conflict_cnt_d = conflict_cnt_q;
    if ((pop > NUM_WPORT) && (conflict_cnt_q != '1)) begin
      conflict_cnt_d = conflict_cnt_q + 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (any_grant) begin
      if (int'(last_idx) == NUM_REQ - 1) rr_ptr_d = '0;
      else                               rr_ptr_d = last_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q       <= '0;
      wrb_valid_q    <= '0;
      wrb_address_q  <= '0;
      wrb_data_q     <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      wrb_valid_q    <= wrb_valid_d;
      wrb_address_q  <= wrb_address_d;
      wrb_data_q     <= wrb_data_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign wrb_valid_o    = wrb_valid_q;
  assign wrb_address_o  = wrb_address_q;
  assign wrb_data_o     = wrb_data_q;
  assign conflict_cnt_o = conflict_cnt_q;

endmodule

// File: tb/tb_wrb_port_arbiter.sv
// Bench for wrb_port_arbiter: directed table, counter saturation, then randomized
// valid/ready traffic against a queue-based reference model.
module tb_wrb_port_arbiter;
  import rcu_pkg::*;

  localparam int N  = 5;
  localparam int W  = 2;
  localparam int AW = 7;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_data  = '0;

  logic [N-1:0]    ready,  ready2;
  logic [W-1:0]    wv,     wv2;
  logic [W*AW-1:0] wa,     wa2;
  logic [W*DW-1:0] wd,     wd2;
  logic [15:0]     cnt;
  logic [3:0]      cnt4;

  wrb_port_arbiter #(.NUM_REQ(N), .NUM_WPORT(W), .REG_SIZE_WIDTH(AW), .XLEN(DW), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_address_i(req_addr), .req_data_i(req_data),
    .req_ready_o(ready), .wrb_valid_o(wv), .wrb_address_o(wa), .wrb_data_o(wd), .conflict_cnt_o(cnt));

  wrb_port_arbiter #(.NUM_REQ(N), .NUM_WPORT(W), .REG_SIZE_WIDTH(AW), .XLEN(DW), .CNT_WIDTH(4)) dut2 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_address_i(req_addr), .req_data_i(req_data),
    .req_ready_o(ready2), .wrb_valid_o(wv2), .wrb_address_o(wa2), .wrb_data_o(wd2), .conflict_cnt_o(cnt4));

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model state
  int              m_rr   = 0;
  int              m_cnt  = 0;
  int              m_cnt4 = 0;
  logic [N-1:0]    m_ready = '0;
  logic [W-1:0]    m_wv = '0;
  logic [W*AW-1:0] m_wa = '0;
  logic [W*DW-1:0] m_wd = '0;
  logic [N-1:0]    smp_ready, smp_ready2;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample comb ready mid-cycle, advance the model, return #1 after the edge.
  task automatic tick();
    int q[$];
    int k;
    int ng;
    logic [AW-1:0] a;
    @(negedge clk);
    smp_ready  = ready;
    smp_ready2 = ready2;
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (req_valid[i] && req_valid[j])
          assert (req_addr[i*AW +: AW] != req_addr[j*AW +: AW]) else $error("duplicate preg %0d/%0d", i, j);
    if (rst) begin
      m_ready = '0; m_wv = '0; m_wa = '0; m_wd = '0;
      m_rr = 0; m_cnt = 0; m_cnt4 = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        k = (m_rr + i) % N;
        if (req_valid[k]) q.push_back(k);
      end
      ng = (q.size() < W) ? q.size() : W;
      m_ready = '0;
      m_wv    = '0;
      for (int j = 0; j < ng; j++) begin
        k = q[j];
        m_ready[k] = 1'b1;
        a = req_addr[k*AW +: AW];
        if (a != 0) begin
          m_wv[j] = 1'b1;
          m_wa[j*AW +: AW] = a;
          m_wd[j*DW +: DW] = req_data[k*DW +: DW];
        end
      end
      if (ng > 0) m_rr = (q[ng-1] + 1) % N;
      if (q.size() > W) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"}, smp_ready, m_ready);
    chk({tag, "_wv"}, wv, m_wv);
    chk({tag, "_wa"}, wa, m_wa);
    chk({tag, "_wd"}, wd, m_wd);
    chk({tag, "_cnt"}, cnt, m_cnt);
    chk({tag, "_cnt4"}, cnt4, m_cnt4);
    chk({tag, "_dut2"}, {smp_ready2, wv2, wa2}, {m_ready, m_wv, m_wa});
    chk({tag, "_dut2wd"}, wd2, m_wd);
  endtask

  typedef struct {
    logic            rst;
    logic [N-1:0]    valid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    exp_ready;
    logic [W-1:0]    exp_wv;
    logic [W*AW-1:0] exp_wa;
    logic [W*DW-1:0] exp_wd;
    int              exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic [N-1:0] v, input logic [N-1:0] rdy,
                              input logic [W-1:0] ev, input int wa1, input int wa0,
                              input longint wd1, input longint wd0, input int c);
    vec_t e;
    e.rst = r;
    e.valid = v;
    for (int k = 0; k < N; k++) begin
      e.addr[k*AW +: AW] = AW'(10 + k);
      e.data[k*DW +: DW] = 64'(256 + k);
    end
    e.exp_ready = rdy;
    e.exp_wv    = ev;
    e.exp_wa    = {AW'(wa1), AW'(wa0)};
    e.exp_wd    = {64'(wd1), 64'(wd0)};
    e.exp_cnt   = c;
    return e;
  endfunction

  vec_t     tbl[11];
  wrb_req_t pend[N];
  int       wait_c[N];

  initial begin
    // Default requester k: preg 10+k, data 0x100+k.
    tbl[0]  = mk(1, 5'b11111, 5'b00000, 2'b00,  0,  0, 0,     0,     0);
    tbl[1]  = mk(0, 5'b00101, 5'b00101, 2'b11,  9,  3, 'hB,   'hA,   0);
    tbl[1].addr[0 +: AW] = 7'd3;  tbl[1].data[0 +: DW] = 64'hA;
    tbl[1].addr[2*AW +: AW] = 7'd9; tbl[1].data[2*DW +: DW] = 64'hB;
    tbl[2]  = mk(1, 5'b00000, 5'b00000, 2'b00,  0,  0, 0,     0,     0);
    tbl[3]  = mk(0, 5'b11111, 5'b00011, 2'b11, 11, 10, 'h101, 'h100, 1);
    tbl[4]  = mk(0, 5'b11111, 5'b01100, 2'b11, 13, 12, 'h103, 'h102, 2);
    tbl[5]  = mk(0, 5'b11111, 5'b10001, 2'b11, 10, 14, 'h100, 'h104, 3);
    tbl[6]  = mk(0, 5'b00010, 5'b00010, 2'b00, 10, 14, 'h100, 'h104, 3);
    tbl[6].addr[AW +: AW] = 7'd0; tbl[6].data[DW +: DW] = 64'hFF;
    tbl[7]  = mk(0, 5'b00011, 5'b00011, 2'b11, 11, 10, 'h101, 'h100, 3);
    tbl[8]  = mk(0, 5'b11111, 5'b01100, 2'b11, 13, 12, 'h103, 'h102, 4);
    tbl[9]  = mk(1, 5'b11111, 5'b00000, 2'b00,  0,  0, 0,     0,     0);
    tbl[10] = mk(0, 5'b11111, 5'b00011, 2'b11, 11, 10, 'h101, 'h100, 1);

    for (int i = 0; i < 11; i++) begin
      rst       = tbl[i].rst;
      req_valid = tbl[i].valid;
      req_addr  = tbl[i].addr;
      req_data  = tbl[i].data;
      tick();
      chk($sformatf("tbl%0d_ready", i), smp_ready, tbl[i].exp_ready);
      chk($sformatf("tbl%0d_wv", i), wv, tbl[i].exp_wv);
      chk($sformatf("tbl%0d_wa", i), wa, tbl[i].exp_wa);
      chk($sformatf("tbl%0d_wd", i), wd, tbl[i].exp_wd);
      chk($sformatf("tbl%0d_cnt", i), cnt, tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_cnt4", i), cnt4, tbl[i].exp_cnt);
    end

    // Saturation: 20 more oversubscribed cycles on top of the count of 1 left above.
    rst = 1'b0;
    req_valid = '1;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_model("sat");
    end
    chk("sat_cnt4_final", cnt4, 4'd15);
    chk("sat_cnt16_final", cnt, 16'd21);
    tick();
    chk("sat_cnt4_hold", cnt4, 4'd15);

    rst = 1'b1;
    req_valid = '0;
    tick();
    check_model("rst");
    for (int k = 0; k < N; k++) begin
      pend[k] = '0;
      wait_c[k] = 0;
    end

    // Random traffic; requesters hold their request until the DUT grants it.
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k].valid && ($urandom_range(0, 99) < 60)) begin
          pend[k].valid   = 1'b1;
          pend[k].address = preg_t'(k*20 + $urandom_range(0, 19));
          pend[k].data    = {$urandom, $urandom};
          wait_c[k]       = 0;
        end
        req_valid[k]           = pend[k].valid;
        req_addr[k*AW +: AW]   = pend[k].address;
        req_data[k*DW +: DW]   = pend[k].data;
      end
      rst = ($urandom_range(0, 49) == 0);
      tick();
      check_model("rnd");
      for (int k = 0; k < N; k++) begin
        if (rst) begin
          wait_c[k] = 0;
        end else if (pend[k].valid && smp_ready[k]) begin
          chk($sformatf("rnd_wait%0d", k), 32'(wait_c[k] <= 2), 32'd1);
          pend[k].valid = 1'b0;
        end else if (pend[k].valid) begin
          wait_c[k]++;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
